mips_regfile_rd: RTL and testbench
==================================

# mips_regfile_rd

Dual-read, single-write general-purpose register file for the MIPS datapath: the read-side counterpart to the pipeline's flip-flop storage. Decode reads two source operands through registered read ports. Writeback writes one destination per cycle. Register 0 is hardwired to zero.

## Interface
- DATA_W, 32, width of each register and of read/write data
- ADDR_W, 5, register address width; depth is 2**ADDR_W
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- we  input  1  write enable from writeback stage
- waddr  input  ADDR_W  destination register index
- wdata  input  DATA_W  write data
- re1  input  1  read enable, port 1 (rs)
- raddr1  input  ADDR_W  read index, port 1
- rdata1  output  DATA_W  registered read data, port 1
- re2  input  1  read enable, port 2 (rt)
- raddr2  input  ADDR_W  read index, port 2
- rdata2  output  DATA_W  registered read data, port 2

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits.
- Write:
  - At a rising edge with we=1 and waddr≠0, entry[waddr] ← wdata.
  - Writes to index 0 are discarded. Entry 0 reads as 0 at all times.
- Read, per port n:
  - At a rising edge with ren=1, rdatan ← entry[raddrn], or 0 if raddrn=0.
  - With ren=0, rdatan holds its previous value.
- Both ports are independent. Both may read the same index in the same cycle; both return identical data.
- Same-edge write/read collision (we=1, ren=1, raddrn=waddr≠0): result depends on REGFILE_BYPASS_EN (see Configuration).
- Reset (reset=0, asynchronous):
  - All entries clear to 0.
  - rdata1 = rdata2 = 0 immediately, independent of clk.
  - While reset is low, writes and reads are ignored.
  - Deassertion takes effect at the first rising edge after reset returns high.
- No internal FSM beyond storage and output registers. The block is never busy and accepts a write and two reads every cycle.

## Timing
- Read latency: 1 cycle. raddrn/ren are sampled at edge k; rdatan is valid after edge k and stable until the next enabled read.
- Write latency: 1 cycle. Data written at edge k is readable by a read sampled at edge k+1, with rdata valid after k+1.
- Reset outputs: rdata1 = 0, rdata2 = 0, all entries = 0.
- Reset asserted mid-operation: any write on the same edge is lost, and outputs clear asynchronously.
- Address/data inputs must be stable around the rising edge. There are no combinational paths from inputs to outputs.

## Configuration
- REGFILE_BYPASS_EN:
  - Defined: a same-edge collision returns wdata on rdatan (write-first forwarding). This lets writeback→decode hazards resolve without a stall.
  - Undefined: a collision returns the pre-write entry value (read-first). The hazard unit must stall one cycle.
  - In both builds, index 0 never forwards and always reads 0.

## Test plan
- Reset: drive reset=0 mid-cycle after filling entries → rdata1 = rdata2 = 0 at once. After release, reading r5 → 0.
- Basic write/read: we=1, waddr=5, wdata=32'hDEADBEEF at edge 1. re1=1, raddr1=5 at edge 2 → rdata1 = 32'hDEADBEEF after edge 2.
- Zero register: write 32'hFFFFFFFF to index 0, then read index 0 on both ports → rdata1 = rdata2 = 0.
- Hold: read r5 (32'hDEADBEEF) with re1=1, then re1=0 while raddr1 changes to 7 → rdata1 stays 32'hDEADBEEF.
- Collision, r9 holding 32'h11111111: write 32'h22222222 to r9 and read r9 on port 2 at the same edge.
  - Bypass build → rdata2 = 32'h22222222.
  - Non-bypass build → rdata2 = 32'h11111111, and the next read → 32'h22222222.
- Dual port: r3 = 32'h3, r31 = 32'h1F. Read raddr1=3 and raddr2=31 at the same edge → rdata1 = 32'h3, rdata2 = 32'h1F.

Source files
------------

// File: rtl/mips_regfile_rd.sv
// Dual-read, single-write MIPS register file with registered read ports; entry 0 reads as zero.
// Define REGFILE_BYPASS_EN for write-first forwarding on a same-edge write/read collision (default: read-first).
module mips_regfile_rd #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);

   localparam int DEPTH = 1 << ADDR_W;

   // Handshake: ren acts as a valid with an always-ready sink; a read issued at edge k
   // is presented on rdatan after edge k and held until the next enabled read.
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata1;
   logic [DATA_W-1:0] r_rdata2;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_wr_ok;

   assign w_wr_ok = we && (waddr != '0);

   always_comb begin
      w_rd1 = r_mem[raddr1];
      w_rd2 = r_mem[raddr2];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (waddr == raddr1)) w_rd1 = wdata;
      if (w_wr_ok && (waddr == raddr2)) w_rd2 = wdata;
`endif
      // Index 0 never forwards and never returns stored data.
      if (raddr1 == '0) w_rd1 = '0;
      if (raddr2 == '0) w_rd2 = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rdata1 <= '0;
         r_rdata2 <= '0;
      end else begin
         if (w_wr_ok) r_mem[waddr] <= wdata;
         if (re1) r_rdata1 <= w_rd1;
         if (re2) r_rdata2 <= w_rd2;
      end
   end

   assign rdata1 = r_rdata1;
   assign rdata2 = r_rdata2;

endmodule

// File: tb/tb_mips_regfile_rd.sv
// Scoreboard bench for mips_regfile_rd: directed vectors push expectations, a monitor pops and compares.
module tb_mips_regfile_rd;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              we = 1'b0;
   logic [ADDR_W-1:0] waddr = '0;
   logic [DATA_W-1:0] wdata = '0;
   logic              re1 = 1'b0;
   logic [ADDR_W-1:0] raddr1 = '0;
   logic [DATA_W-1:0] rdata1;
   logic              re2 = 1'b0;
   logic [ADDR_W-1:0] raddr2 = '0;
   logic [DATA_W-1:0] rdata2;

   logic              chk1 = 1'b0;
   logic              chk2 = 1'b0;
   logic [DATA_W-1:0] exp1_q[$];
   logic [DATA_W-1:0] exp2_q[$];
   int checks = 0;
   int failures = 0;

   mips_regfile_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Driver: inputs change on the falling edge, sampled by the DUT at the next rising edge.
   task automatic cyc(input logic w, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic r1, input logic [ADDR_W-1:0] a1, input logic c1,
                      input logic [DATA_W-1:0] e1,
                      input logic r2, input logic [ADDR_W-1:0] a2, input logic c2,
                      input logic [DATA_W-1:0] e2);
      @(negedge clk);
      we = w; waddr = wa; wdata = wd;
      re1 = r1; raddr1 = a1; chk1 = c1;
      re2 = r2; raddr2 = a2; chk2 = c2;
      if (c1) exp1_q.push_back(e1);
      if (c2) exp2_q.push_back(e2);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: a port flagged at a rising edge is compared on the following falling edge.
   always begin
      logic s1, s2;
      @(posedge clk);
      s1 = chk1;
      s2 = chk2;
      @(negedge clk);
      if (s1) begin
         if (exp1_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL port1_queue: got empty queue expected an entry");
         end else check("port1_read", rdata1, exp1_q.pop_front());
      end
      if (s2) begin
         if (exp2_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL port2_queue: got empty queue expected an entry");
         end else check("port2_read", rdata2, exp2_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] coll_exp;
`ifdef REGFILE_BYPASS_EN
      coll_exp = 32'h22222222;
`else
      coll_exp = 32'h11111111;
`endif
      // Reset state, with a clock running.
      repeat (3) @(posedge clk);
      #1;
      check("reset_rdata1", rdata1, '0);
      check("reset_rdata2", rdata2, '0);
      @(negedge clk);
      reset = 1'b1;

      //  we wa  wdata          re1 a1 c1 e1             re2 a2 c2 e2
      cyc(1, 5,  32'hDEADBEEF,  0, 0, 0, 0,             0, 0, 0, 0);
      cyc(1, 7,  32'h00000077,  1, 5, 1, 32'hDEADBEEF,  1, 5, 1, 32'hDEADBEEF);
      cyc(1, 0,  32'hFFFFFFFF,  0, 0, 0, 0,             0, 0, 0, 0);
      cyc(0, 0,  0,             1, 0, 1, 32'h0,         1, 0, 1, 32'h0);
      cyc(0, 0,  0,             1, 5, 1, 32'hDEADBEEF,  1, 7, 1, 32'h00000077);
      cyc(0, 0,  0,             0, 7, 1, 32'hDEADBEEF,  0, 5, 1, 32'h00000077);
      cyc(1, 9,  32'h11111111,  0, 0, 0, 0,             0, 0, 0, 0);
      cyc(1, 9,  32'h22222222,  0, 0, 0, 0,             1, 9, 1, coll_exp);
      cyc(0, 0,  0,             1, 9, 1, 32'h22222222,  1, 9, 1, 32'h22222222);
      // A write to index 0 colliding with a read of index 0 must still return zero.
      cyc(1, 0,  32'hABCDABCD,  1, 0, 1, 32'h0,         1, 0, 1, 32'h0);
      cyc(1, 3,  32'h00000003,  0, 0, 0, 0,             0, 0, 0, 0);
      cyc(1, 31, 32'h0000001F,  0, 0, 0, 0,             0, 0, 0, 0);
      cyc(0, 0,  0,             1, 3, 1, 32'h00000003,  1, 31, 1, 32'h0000001F);
      idle();
      idle();

      // Asynchronous reset mid-cycle with a write pending on the same edge.
      we = 1'b1; waddr = 5'd5; wdata = 32'h55555555;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midreset_rdata1", rdata1, '0);
      check("midreset_rdata2", rdata2, '0);
      @(posedge clk);
      #1;
      check("hold_reset_rdata1", rdata1, '0);
      @(negedge clk);
      reset = 1'b1;
      we = 1'b0;
      cyc(0, 0,  0,             1, 5, 1, 32'h0,         1, 3, 1, 32'h0);
      cyc(0, 0,  0,             1, 31, 1, 32'h0,        1, 9, 1, 32'h0);
      idle();
      idle();

      if (exp1_q.size() != 0 || exp2_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL queue_drain: got %0d/%0d left expected 0/0", exp1_q.size(), exp2_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
